// File: rtl/mac_pipe_arbiter_if.sv
// Bus bundle joining the two operand producers, mac_pipe_arbiter and the
// shared multiply-add datapath (operands out, result back, per-owner responses).
interface mac_pipe_arbiter_if;
    logic        req0_valid;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        req1_ready;
    logic [7:0]  dp_a;
    logic [7:0]  dp_b;
    logic [15:0] dp_g;
    logic        rsp0_valid;
    logic [15:0] rsp0_data;
    logic        rsp1_valid;
    logic [15:0] rsp1_data;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  dp_g,
        output req0_ready, req1_ready,
        output dp_a, dp_b,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output dp_g,
        input  req0_ready, req1_ready,
        input  dp_a, dp_b,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/mac_pipe_arbiter.sv
// Round-robin sharing of one fixed-latency multiply-add pipeline between two requesters,
// with tag-tracked result routing and drain-to-idle. Optional grant statistics: MAC_ARB_STATS_EN.
module mac_pipe_arbiter #(
    parameter int DP_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    mac_pipe_arbiter_if.slave bus,
    output logic              busy
`ifdef MAC_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    logic            prio_r;
    logic [DP_LAT:0] tag_v_r;
    logic [DP_LAT:0] tag_id_r;
    logic [7:0]      dp_a_r;
    logic [7:0]      dp_b_r;
    logic            gnt_v_s;
    logic            gnt_id_s;
    logic            pipe_drained_s;

    // Round-robin grant; prio_r names the requester that wins a tie
    always_comb begin
        gnt_v_s  = 1'b0;
        gnt_id_s = 1'b0;
        if (state_r == ST_RUN) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_v_s  = 1'b1;
                gnt_id_s = prio_r;
            end else if (bus.req0_valid) begin
                gnt_v_s  = 1'b1;
                gnt_id_s = 1'b0;
            end else if (bus.req1_valid) begin
                gnt_v_s  = 1'b1;
                gnt_id_s = 1'b1;
            end else begin
                gnt_v_s  = 1'b0;
                gnt_id_s = 1'b0;
            end
        end else begin
            gnt_v_s  = 1'b0;
            gnt_id_s = 1'b0;
        end
    end

    assign bus.req0_ready = gnt_v_s && !gnt_id_s;
    assign bus.req1_ready = gnt_v_s && gnt_id_s;

    // Only the last stage may still hold a result: the pipe is empty after this edge
    assign pipe_drained_s = (tag_v_r[DP_LAT-1:0] == {DP_LAT{1'b0}});

    // Run/drain/idle control
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (en) begin
                        state_r <= ST_RUN;
                    end else if (pipe_drained_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand register, tie-break pointer and owner tag pipe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_v_r  <= {(DP_LAT+1){1'b0}};
            tag_id_r <= {(DP_LAT+1){1'b0}};
            dp_a_r   <= 8'h00;
            dp_b_r   <= 8'h00;
            prio_r   <= 1'b0;
        end else begin
            tag_v_r  <= {tag_v_r[DP_LAT-1:0], gnt_v_s};
            tag_id_r <= {tag_id_r[DP_LAT-1:0], gnt_id_s};
            if (gnt_v_s) begin
                dp_a_r <= gnt_id_s ? bus.req1_a : bus.req0_a;
                dp_b_r <= gnt_id_s ? bus.req1_b : bus.req0_b;
                prio_r <= ~gnt_id_s;
            end else begin
                dp_a_r <= 8'h00;
                dp_b_r <= 8'h00;
            end
        end
    end

    assign bus.dp_a       = dp_a_r;
    assign bus.dp_b       = dp_b_r;
    assign bus.rsp0_valid = tag_v_r[DP_LAT] && !tag_id_r[DP_LAT];
    assign bus.rsp1_valid = tag_v_r[DP_LAT] && tag_id_r[DP_LAT];
    assign bus.rsp0_data  = bus.dp_g;
    assign bus.rsp1_data  = bus.dp_g;
    assign busy           = (state_r != ST_IDLE) || (|tag_v_r);

`ifdef MAC_ARB_STATS_EN
    logic [15:0] grant_cnt0_r;
    logic [15:0] grant_cnt1_r;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? 16'hFFFF : (val + 16'h0001);
    endfunction

    // Per-requester saturating grant counters, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt0_r <= 16'h0000;
            grant_cnt1_r <= 16'h0000;
        end else begin
            if (gnt_v_s && !gnt_id_s) begin
                grant_cnt0_r <= sat_inc(grant_cnt0_r);
            end
            if (gnt_v_s && gnt_id_s) begin
                grant_cnt1_r <= sat_inc(grant_cnt1_r);
            end
        end
    end

    assign grant_cnt0 = grant_cnt0_r;
    assign grant_cnt1 = grant_cnt1_r;
`endif

endmodule

// File: tb/tb_mac_pipe_arbiter.sv
// Directed bench for mac_pipe_arbiter: a 4-stage datapath model feeds dp_g, a scoreboard
// queue holds expected owner/data/cycle per accepted operation and is checked on each pulse.
module tb_mac_pipe_arbiter;

    logic clk;
    logic reset;
    logic en;
    logic busy;
`ifdef MAC_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    mac_pipe_arbiter_if bus ();

    mac_pipe_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus),
        .busy  (busy)
`ifdef MAC_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    typedef struct {
        logic        id;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [7:0]  exp_dpa = 8'h00;
    logic [7:0]  exp_dpb = 8'h00;
    logic [15:0] dpp [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Free-running datapath: result appears 4 edges after its operands
    always @(posedge clk) begin
        dpp[0] <= 16'(bus.dp_a) * 16'(bus.dp_b) + 16'h004E;
        dpp[1] <= dpp[0];
        dpp[2] <= dpp[1];
        dpp[3] <= dpp[2];
    end
    assign bus.dp_g = dpp[3];

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic id, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.id   = id;
        e.data = 16'(a) * 16'(b) + 16'h004E;
        e.due  = cyc + 5;
        sbq.push_back(e);
    endtask

    // One cycle: check operands registered last edge, drive inputs, check ready, record expectation
    task automatic step(input logic e, input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                        input logic x0, input logic x1);
        @(negedge clk);
        chk("dp_a", 16'(bus.dp_a), 16'(exp_dpa));
        chk("dp_b", 16'(bus.dp_b), 16'(exp_dpb));
        en             = e;
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        #1;
        chk("req0_ready", 16'(bus.req0_ready), 16'(x0));
        chk("req1_ready", 16'(bus.req1_ready), 16'(x1));
        if (x0) begin
            push(1'b0, a0, b0);
            exp_dpa = a0;
            exp_dpb = b0;
        end else if (x1) begin
            push(1'b1, a1, b1);
            exp_dpa = a1;
            exp_dpb = b1;
        end else begin
            exp_dpa = 8'h00;
            exp_dpb = 8'h00;
        end
    endtask

    task automatic idle(input logic e);
        step(e, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drain_wait(input string tag);
        for (int i = 0; i < 30 && sbq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk(tag, 16'(sbq.size()), 16'h0000);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req0_ready"}, 16'(bus.req0_ready), 16'h0000);
        chk({tag, "_req1_ready"}, 16'(bus.req1_ready), 16'h0000);
        chk({tag, "_dp_a"},       16'(bus.dp_a),       16'h0000);
        chk({tag, "_dp_b"},       16'(bus.dp_b),       16'h0000);
        chk({tag, "_rsp0_valid"}, 16'(bus.rsp0_valid), 16'h0000);
        chk({tag, "_rsp1_valid"}, 16'(bus.rsp1_valid), 16'h0000);
        chk({tag, "_busy"},       16'(busy),           16'h0000);
    endtask

    // Response monitor: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.rsp0_valid || bus.rsp1_valid) begin
            chk("rsp_onehot", 16'(bus.rsp0_valid & bus.rsp1_valid), 16'h0000);
            total++;
            assert (sbq.size() != 0) else begin
                bad++;
                $error("FAIL rsp_unexpected: observed rsp0_valid=%0b rsp1_valid=%0b expected no pulse",
                       bus.rsp0_valid, bus.rsp1_valid);
            end
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("rsp_owner", 16'(bus.rsp1_valid), 16'(mon_e.id));
                chk("rsp_data", bus.rsp1_valid ? bus.rsp1_data : bus.rsp0_data, mon_e.data);
                chk("rsp_cycle", 16'(cyc), 16'(mon_e.due));
            end
        end
    end

    initial begin
        reset          = 1'b0;
        en             = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req0_a     = 8'h00;
        bus.req0_b     = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_a     = 8'h00;
        bus.req1_b     = 8'h00;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
`ifdef MAC_ARB_STATS_EN
        chk("rst_cnt0", grant_cnt0, 16'h0000);
        chk("rst_cnt1", grant_cnt1, 16'h0000);
`endif
        @(negedge clk);
        reset = 1'b1;

        // IDLE offers no grant and is not busy
        step(1'b0, 1'b1, 8'd3, 8'd5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        chk("idle_busy", 16'(busy), 16'h0000);

        // Single op: 3*5+0x4E = 0x005D to requester 0
        idle(1'b1);
        step(1'b1, 1'b1, 8'd3, 8'd5, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(1'b1);
        chk("single_busy", 16'(busy), 16'h0001);
        drain_wait("single_done");

        // req1 alone three times, then contention starts with req0 and alternates
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i + 1), 8'(i + 10), 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h02, 8'h02, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h02, 8'h02, 1'b0, 1'b1);
        step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h02, 8'h02, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h02, 8'h02, 1'b0, 1'b1);
        idle(1'b1);
        drain_wait("contention_done");

        // Drain: third op accepted on the edge where en falls, nothing granted afterwards
        step(1'b1, 1'b1, 8'd10, 8'd11, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b1, 8'd12, 8'd13, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 8'd14, 8'd15, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b1, 8'd16, 8'd17, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
            chk("drain_busy", 16'(busy), (k <= 5) ? 16'h0001 : 16'h0000);
        end
        idle(1'b0);
        drain_wait("drain_done");

        // Reset two cycles after two accepted ops: their responses must never appear
        idle(1'b1);
        step(1'b1, 1'b1, 8'd7, 8'd9, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'd4, 8'd4, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        reset          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        sbq.delete();
        exp_dpa        = 8'h00;
        exp_dpb        = 8'h00;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) idle(1'b0);

        // Post-reset traffic: 5 req0 ops then 2 req1 ops
        idle(1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 8'(i * 50 + 5), 8'(255 - i * 3), 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i + 200), 8'(i + 100), 1'b0, 1'b1);
        idle(1'b1);
        drain_wait("post_reset_done");
`ifdef MAC_ARB_STATS_EN
        chk("cnt0_after7", grant_cnt0, 16'd5);
        chk("cnt1_after7", grant_cnt1, 16'd2);
        for (int i = 0; i < 65535; i++)
            step(1'b1, 1'b1, 8'(i), 8'(i >> 8), 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(1'b1);
        drain_wait("sat_done");
        chk("cnt0_saturated", grant_cnt0, 16'hFFFF);
        chk("cnt1_held", grant_cnt1, 16'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_pipe_arbiter.md
# mac_pipe_arbiter

Shares the single multiply-add pipeline (g = a*b + 0x004E, fixed 4-cycle latency, free-running, no handshake) between two requesters. The block arbitrates round-robin and registers the winning operands onto the datapath inputs. It tracks each in-flight operation with a tag pipe and routes each result back to its owner as a one-cycle pulse. It sits between the two operand producers and the datapath instance, and supports a drain/idle sequence for safe reconfiguration.

## Interface
- DP_LAT, 4, edges from a datapath input change to the corresponding result on dp_g; tag pipe depth is DP_LAT+1
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low
- en  in  1  1 = grant requests; 0 = stop granting, drain, go idle
- req0_valid / req1_valid  in  1  requester has operands pending
- req0_a, req0_b / req1_a, req1_b  in  8 each  operands
- req0_ready / req1_ready  out  1  transfer occurs on an edge where valid && ready
- dp_a, dp_b  out  8 each  registered operands to the datapath
- dp_g  in  16  datapath result
- rsp0_valid / rsp1_valid  out  1  one-cycle result pulse to the owner
- rsp0_data / rsp1_data  out  16  equal to dp_g, valid only while the matching rsp valid is high
- busy  out  1  high when any tag-pipe stage is valid or the state is not IDLE
- grant_cnt0, grant_cnt1  out  16 each  present only with MAC_ARB_STATS_EN

## Operation
- States: IDLE, RUN, DRAIN. Reset enters IDLE.
- IDLE -> RUN when en=1. RUN -> DRAIN when en=0. DRAIN -> IDLE when the tag pipe is empty. DRAIN -> RUN if en returns to 1 before the pipe is empty.
- Grant is combinational and issued only in RUN:
  - One valid requester: that requester wins.
  - Both valid: the requester not granted last wins.
  - Priority pointer: resets to favour req0, updates only on an accepted transfer.
- reqX_ready = (state==RUN) && (grant==X). The non-granted requester sees ready=0. The other ready is 0 in IDLE and DRAIN.
- On acceptance edge E0:
  - dp_a/dp_b <= winner's operands.
  - Tag stage 0 <= {valid=1, id=X}.
- On any edge without acceptance: dp_a/dp_b <= 0 and tag stage 0 <= invalid.
- Tag pipe shifts every edge. rspX_valid = last stage valid && id==X.
- rspX_data mirrors dp_g at all times. Consumers must qualify it with rspX_valid.
- Result = a*b + 0x004E. This is 16-bit exact (max 0xFE4F), so no overflow handling is needed.
- At most one rsp valid is high in any cycle.

## Timing
- Reset values: req*_ready=0, dp_a=dp_b=0, all tags invalid, rsp*_valid=0, busy=0, pointer=req0, grant counters=0.
- Latency: acceptance at edge E0 gives rspX_valid high for exactly the cycle after edge E0+DP_LAT (DP_LAT+1 edges total).
- Throughput: one acceptance per cycle, back-to-back. Alternating grants occur under continuous contention.
- Responses have no back-pressure. A requester that is not ready to take a response loses it.
- en falling on an acceptance edge: that transfer completes normally. No new grant is issued after that edge.
- Reset mid-operation: in-flight tags are cleared and their responses are never issued. Datapath contents after reset are ignored.
- In DRAIN: busy stays 1 until the last response cycle ends. It falls on the edge that empties the tag pipe.

## Configuration
- MAC_ARB_STATS_EN defined:
  - grant_cnt0/grant_cnt1 ports exist.
  - Each counter increments on every accepted transfer for its requester and saturates at 0xFFFF.
  - Counters are cleared by reset only.
- MAC_ARB_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Single op: en=1, req0 a=3 b=5 accepted at E0 -> rsp0_valid one cycle after E0+4 with data 0x005D; rsp1_valid stays 0.
- Contention: both valid for 4 cycles (req0 a=0xFF b=0xFF, req1 a=2 b=2) -> grants alternate req0, req1, req0, req1; responses 0xFE4F, 0x0052 alternate in the same order, one per cycle.
- Drain: 3 ops in flight, then en=0 -> no further ready; all 3 responses delivered; busy falls after the last one; state IDLE.
- Reset mid-flight: 2 ops accepted, reset asserted 2 cycles later -> no rsp valid pulses; all outputs at reset values; a post-reset op returns a correct result.
- Pointer fairness: req1 only for 3 ops, then both valid -> req0 granted first.
- With MAC_ARB_STATS_EN: 5 req0 grants and 2 req1 grants -> grant_cnt0=5, grant_cnt1=2. A counter preloaded near 0xFFFF holds at 0xFFFF.
